// File: rtl/coh_noc_pkg.sv
// Shared coherent-NoC types: writeback entry states, request opcodes and line geometry.
package coh_noc_pkg;

  localparam int unsigned LINE_OFFSET_W = 6;
  localparam int unsigned ADDR_W        = 48;
  localparam int unsigned LINE_W        = 512;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DBID = 2'd2,
    DATA      = 2'd3
  } wb_state_e;

  typedef enum logic [3:0] {
    REQ_READ_SHARED    = 4'h0,
    REQ_READ_UNIQUE    = 4'h1,
    REQ_WRITEBACK_FULL = 4'h8
  } req_opcode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a grant lock: once presented, a grant holds until advance.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 valid
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] lock_idx_q;
  logic             lock_q;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_found;

  // First requester at or after the pointer, wrapping (N is a power of two).
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!rr_found && req[ptr_q + IDX_W'(k)]) begin
        rr_found = 1'b1;
        rr_idx   = ptr_q + IDX_W'(k);
      end
    end
  end

  assign grant_idx = lock_q ? lock_idx_q : rr_idx;
  assign valid     = lock_q | rr_found;
  assign grant     = valid ? (N'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (valid && advance) begin
      ptr_q  <= grant_idx + IDX_W'(1);
      lock_q <= 1'b0;
    end else if (valid) begin
      lock_q     <= 1'b1;
      lock_idx_q <= grant_idx;
    end
  end

endmodule

// File: rtl/l1_wb_buffer.sv
// L1 victim writeback buffer: drops clean victims, drains dirty ones as WriteBackFull
// (req, CompDBIDResp, data) and serves fill/snoop lookups while lines are in flight.
module l1_wb_buffer
  import coh_noc_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned TXNID_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           evict_valid,
  output logic                           evict_ready,
  input  logic [47:0]                    evict_addr,
  input  logic [511:0]                   evict_data,
  input  logic                           evict_dirty,
  output logic                           req_valid,
  input  logic                           req_ready,
  output req_opcode_e                    req_opcode,
  output logic [47:0]                    req_addr,
  output logic [TXNID_WIDTH-1:0]         req_txnid,
  input  logic                           rsp_valid,
  input  logic [TXNID_WIDTH-1:0]         rsp_txnid,
  input  logic [TXNID_WIDTH-1:0]         rsp_dbid,
  output logic                           dat_valid,
  input  logic                           dat_ready,
  output logic [TXNID_WIDTH-1:0]         dat_txnid,
  output logic [511:0]                   dat_data,
  input  logic [47:0]                    lookup_addr,
  output logic                           lookup_hit,
  output logic [511:0]                   lookup_data,
  output logic                           rsp_err,
  output logic [$clog2(NUM_ENTRIES):0]   occupancy
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam int unsigned OCC_W = IDX_W + 1;
  localparam int unsigned TAG_W = ADDR_W - LINE_OFFSET_W;

  wb_state_e                st_q [NUM_ENTRIES];
  wb_state_e                st_d [NUM_ENTRIES];
  logic [TAG_W-1:0]         tag_q  [NUM_ENTRIES];
  logic [LINE_W-1:0]        data_q [NUM_ENTRIES];
  logic [TXNID_WIDTH-1:0]   dbid_q [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0]   free_vec, req_vec, data_vec, wait_match;
  logic [NUM_ENTRIES-1:0]   req_grant, dat_grant;
  logic [IDX_W-1:0]         req_idx, dat_idx, alloc_idx;
  logic [OCC_W-1:0]         occ_q;
  logic                     rsp_err_q;
  logic                     alloc, req_fire, dat_fire;
  logic                     unused_offset;

  assign unused_offset = ^{evict_addr[LINE_OFFSET_W-1:0], lookup_addr[LINE_OFFSET_W-1:0]};

  always_comb begin
    free_vec   = '0;
    req_vec    = '0;
    data_vec   = '0;
    wait_match = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      free_vec[i]   = (st_q[i] == FREE);
      req_vec[i]    = (st_q[i] == REQ);
      data_vec[i]   = (st_q[i] == DATA);
      wait_match[i] = rsp_valid && (st_q[i] == WAIT_DBID) && (rsp_txnid == TXNID_WIDTH'(i));
    end
  end

  // Lowest-index free entry; ready looks only at registered state.
  always_comb begin
    alloc_idx = '0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign evict_ready = |free_vec;
  assign alloc       = evict_valid && evict_ready && evict_dirty;
  assign req_fire    = req_valid && req_ready;
  assign dat_fire    = dat_valid && dat_ready;

  rr_arbiter #(.N(NUM_ENTRIES)) u_req_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_vec),
    .advance   (req_fire),
    .grant     (req_grant),
    .grant_idx (req_idx),
    .valid     (req_valid)
  );

  rr_arbiter #(.N(NUM_ENTRIES)) u_dat_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (data_vec),
    .advance   (dat_fire),
    .grant     (dat_grant),
    .grant_idx (dat_idx),
    .valid     (dat_valid)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      st_d[i] = st_q[i];
      unique case (st_q[i])
        FREE:      if (alloc && (alloc_idx == IDX_W'(i))) st_d[i] = REQ;
        REQ:       if (req_fire && req_grant[i])           st_d[i] = WAIT_DBID;
        WAIT_DBID: if (wait_match[i])                      st_d[i] = DATA;
        DATA:      if (dat_fire && dat_grant[i])           st_d[i] = FREE;
        default:                                           st_d[i] = FREE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) st_q[i] <= FREE;
      occ_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) st_q[i] <= st_d[i];
      occ_q     <= occ_q + OCC_W'(alloc) - OCC_W'(dat_fire);
      rsp_err_q <= rsp_valid && !(|wait_match);
    end
  end

  // Payload storage needs no reset: every read is qualified by entry state.
  always_ff @(posedge clk) begin
    if (alloc) begin
      tag_q[alloc_idx]  <= evict_addr[ADDR_W-1:LINE_OFFSET_W];
      data_q[alloc_idx] <= evict_data;
    end
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (wait_match[i]) dbid_q[i] <= rsp_dbid;
    end
  end

  // Lowest matching non-free entry wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if ((st_q[i] != FREE) && (tag_q[i] == lookup_addr[ADDR_W-1:LINE_OFFSET_W])) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[i];
      end
    end
  end

  assign req_opcode = REQ_WRITEBACK_FULL;
  assign req_addr   = req_valid ? {tag_q[req_idx], {LINE_OFFSET_W{1'b0}}} : '0;
  assign req_txnid  = req_valid ? TXNID_WIDTH'(req_idx) : '0;
  assign dat_txnid  = dat_valid ? dbid_q[dat_idx] : '0;
  assign dat_data   = dat_valid ? data_q[dat_idx] : '0;
  assign rsp_err    = rsp_err_q;
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_l1_wb_buffer.sv
// Scoreboard bench for l1_wb_buffer: request and data beats are checked against queues.
module tb_l1_wb_buffer;
  import coh_noc_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         evict_valid, evict_ready, evict_dirty;
  logic [47:0]  evict_addr;
  logic [511:0] evict_data;
  logic         req_valid, req_ready;
  req_opcode_e  req_opcode;
  logic [47:0]  req_addr;
  logic [7:0]   req_txnid;
  logic         rsp_valid;
  logic [7:0]   rsp_txnid, rsp_dbid;
  logic         dat_valid, dat_ready;
  logic [7:0]   dat_txnid;
  logic [511:0] dat_data;
  logic [47:0]  lookup_addr;
  logic         lookup_hit;
  logic [511:0] lookup_data;
  logic         rsp_err;
  logic [2:0]   occupancy;

  typedef struct { logic [47:0] addr; logic [7:0] txnid; } req_exp_t;
  typedef struct { int entry; logic [7:0] dbid; logic [511:0] data; } dat_exp_t;

  req_exp_t     req_q[$];
  dat_exp_t     dat_q[$];
  req_exp_t     mon_r;
  dat_exp_t     mon_d;
  logic [3:0]   busy;
  logic [511:0] mdata [4];
  int           checks;
  int           passes;

  l1_wb_buffer #(.NUM_ENTRIES(4), .TXNID_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .evict_valid (evict_valid),
    .evict_ready (evict_ready),
    .evict_addr  (evict_addr),
    .evict_data  (evict_data),
    .evict_dirty (evict_dirty),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opcode  (req_opcode),
    .req_addr    (req_addr),
    .req_txnid   (req_txnid),
    .rsp_valid   (rsp_valid),
    .rsp_txnid   (rsp_txnid),
    .rsp_dbid    (rsp_dbid),
    .dat_valid   (dat_valid),
    .dat_ready   (dat_ready),
    .dat_txnid   (dat_txnid),
    .dat_data    (dat_data),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .rsp_err     (rsp_err),
    .occupancy   (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] pat(input logic [7:0] b);
    return {64{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference allocation: lowest free entry takes the victim.
  task automatic model_alloc(input logic [47:0] addr, input logic [511:0] data);
    int idx;
    idx = -1;
    for (int i = 3; i >= 0; i--) if (!busy[i]) idx = i;
    if (idx >= 0) begin
      busy[idx]  = 1'b1;
      mdata[idx] = data;
      req_q.push_back('{addr & ~48'h3F, 8'(idx)});
    end
  endtask

  task automatic do_evict(input logic [47:0] addr, input logic [511:0] data, input logic dirty);
    int n;
    n = 0;
    while (evict_ready !== 1'b1 && n < 50) begin tick(); n++; end
    if (evict_ready !== 1'b1) begin
      checks++;
      $display("FAIL evict_timeout evict_ready=%b required 1", evict_ready);
      return;
    end
    evict_valid = 1'b1; evict_addr = addr; evict_data = data; evict_dirty = dirty;
    if (dirty) model_alloc(addr, data);
    tick();
    evict_valid = 1'b0; evict_dirty = 1'b0;
  endtask

  task automatic drain_reqs();
    int n;
    n = 0;
    req_ready = 1'b1;
    while (req_q.size() != 0 && n < 20) begin tick(); n++; end
    req_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick(); tick();
    req_q.delete(); dat_q.delete(); busy = '0;
    rst_n = 1'b1;
  endtask

  // Scoreboard: compare every handshake that the next edge will complete.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (req_valid && req_ready) begin
        checks++;
        if (req_q.size() == 0) begin
          $display("FAIL req_unexpected txnid=%0h addr=%0h required no request", req_txnid, req_addr);
        end else begin
          mon_r = req_q.pop_front();
          if (req_addr !== mon_r.addr || req_txnid !== mon_r.txnid || req_opcode !== REQ_WRITEBACK_FULL)
            $display("FAIL req_beat got addr=%0h txnid=%0h op=%0h required addr=%0h txnid=%0h op=%0h",
                     req_addr, req_txnid, req_opcode, mon_r.addr, mon_r.txnid, REQ_WRITEBACK_FULL);
          else passes++;
        end
      end
      if (dat_valid && dat_ready) begin
        checks++;
        if (dat_q.size() == 0) begin
          $display("FAIL dat_unexpected txnid=%0h required no data beat", dat_txnid);
        end else begin
          mon_d = dat_q.pop_front();
          busy[mon_d.entry] = 1'b0;
          if (dat_txnid !== mon_d.dbid || dat_data !== mon_d.data)
            $display("FAIL dat_beat got txnid=%0h data[31:0]=%0h required txnid=%0h data[31:0]=%0h",
                     dat_txnid, dat_data[31:0], mon_d.dbid, mon_d.data[31:0]);
          else passes++;
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    checks++; if (evict_ready !== 1'b1) $display("FAIL rst_evict_ready got=%b required=1", evict_ready); else passes++;
    checks++; if (req_valid !== 1'b0) $display("FAIL rst_req_valid got=%b required=0", req_valid); else passes++;
    checks++; if (dat_valid !== 1'b0) $display("FAIL rst_dat_valid got=%b required=0", dat_valid); else passes++;
    checks++; if (req_opcode !== REQ_WRITEBACK_FULL) $display("FAIL rst_opcode got=%0h required=%0h", req_opcode, REQ_WRITEBACK_FULL); else passes++;
    checks++; if (req_addr !== 48'h0) $display("FAIL rst_req_addr got=%0h required=0", req_addr); else passes++;
    checks++; if (req_txnid !== 8'h0) $display("FAIL rst_req_txnid got=%0h required=0", req_txnid); else passes++;
    checks++; if (dat_txnid !== 8'h0) $display("FAIL rst_dat_txnid got=%0h required=0", dat_txnid); else passes++;
    checks++; if (dat_data !== 512'h0) $display("FAIL rst_dat_data got=%0h required=0", dat_data[63:0]); else passes++;
    checks++; if (lookup_hit !== 1'b0) $display("FAIL rst_lookup_hit got=%b required=0", lookup_hit); else passes++;
    checks++; if (lookup_data !== 512'h0) $display("FAIL rst_lookup_data got=%0h required=0", lookup_data[63:0]); else passes++;
    checks++; if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err got=%b required=0", rsp_err); else passes++;
    checks++; if (occupancy !== 3'd0) $display("FAIL rst_occupancy got=%0d required=0", occupancy); else passes++;
  endtask

  task automatic test_single_dirty();
    do_evict(48'h1234_5678_9A40, pat(8'hA5), 1'b1);
    checks++; if (req_valid !== 1'b1) $display("FAIL single_req_valid got=%b required=1", req_valid); else passes++;
    checks++; if (req_txnid !== 8'h00) $display("FAIL single_req_txnid got=%0h required=0", req_txnid); else passes++;
    checks++; if (occupancy !== 3'd1) $display("FAIL single_occ got=%0d required=1", occupancy); else passes++;
    drain_reqs();
    checks++; if (req_valid !== 1'b0) $display("FAIL single_req_done got=%b required=0", req_valid); else passes++;
    rsp_valid = 1'b1; rsp_txnid = 8'h00; rsp_dbid = 8'h3C;
    dat_q.push_back('{0, 8'h3C, pat(8'hA5)});
    tick();
    rsp_valid = 1'b0;
    checks++; if (dat_valid !== 1'b1) $display("FAIL single_dat_valid got=%b required=1", dat_valid); else passes++;
    checks++; if (dat_txnid !== 8'h3C) $display("FAIL single_dat_txnid got=%0h required=3c", dat_txnid); else passes++;
    checks++; if (rsp_err !== 1'b0) $display("FAIL single_rsp_err got=%b required=0", rsp_err); else passes++;
    dat_ready = 1'b1;
    tick();
    dat_ready = 1'b0;
    checks++; if (dat_valid !== 1'b0) $display("FAIL single_dat_done got=%b required=0", dat_valid); else passes++;
    checks++; if (occupancy !== 3'd0) $display("FAIL single_occ_end got=%0d required=0", occupancy); else passes++;
  endtask

  task automatic test_clean();
    checks++; if (evict_ready !== 1'b1) $display("FAIL clean_ready got=%b required=1", evict_ready); else passes++;
    do_evict(48'h0000_0000_8000, pat(8'h3C), 1'b0);
    checks++; if (req_valid !== 1'b0) $display("FAIL clean_req_valid got=%b required=0", req_valid); else passes++;
    checks++; if (occupancy !== 3'd0) $display("FAIL clean_occ got=%0d required=0", occupancy); else passes++;
  endtask

  task automatic test_rr_order();
    apply_reset();
    for (int i = 0; i < 3; i++) do_evict(48'h1000 * 48'(i + 1), pat(8'(8'h10 + i)), 1'b1);
    checks++; if (occupancy !== 3'd3) $display("FAIL rr_occ got=%0d required=3", occupancy); else passes++;
    drain_reqs();
    checks++; if (req_q.size() != 0) $display("FAIL rr_req_drain left=%0d required=0", req_q.size()); else passes++;
    dat_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 3) begin
        rsp_valid = 1'b1; rsp_txnid = 8'(2 - c); rsp_dbid = 8'(8'h52 - c);
        dat_q.push_back('{2 - c, 8'(8'h52 - c), mdata[2 - c]});
      end else begin
        rsp_valid = 1'b0;
      end
      tick();
    end
    dat_ready = 1'b0;
    checks++; if (dat_q.size() != 0) $display("FAIL rr_dat_drain left=%0d required=0", dat_q.size()); else passes++;
    checks++; if (occupancy !== 3'd0) $display("FAIL rr_occ_end got=%0d required=0", occupancy); else passes++;
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 4; i++) do_evict(48'h2_0000 + 48'(i) * 48'h40, pat(8'(8'h20 + i)), 1'b1);
    checks++; if (occupancy !== 3'd4) $display("FAIL full_occ got=%0d required=4", occupancy); else passes++;
    checks++; if (evict_ready !== 1'b0) $display("FAIL full_ready got=%b required=0", evict_ready); else passes++;
    evict_valid = 1'b1; evict_addr = 48'h3_0000; evict_data = pat(8'h55); evict_dirty = 1'b1;
    tick(); tick();
    checks++; if (occupancy !== 3'd4) $display("FAIL full_stall_occ got=%0d required=4", occupancy); else passes++;
    drain_reqs();
    checks++; if (req_q.size() != 0) $display("FAIL full_req_drain left=%0d required=0", req_q.size()); else passes++;
    rsp_valid = 1'b1; rsp_txnid = 8'h02; rsp_dbid = 8'h77;
    dat_q.push_back('{2, 8'h77, mdata[2]});
    tick();
    rsp_valid = 1'b0;
    checks++; if (evict_ready !== 1'b0) $display("FAIL full_ready_data got=%b required=0", evict_ready); else passes++;
    dat_ready = 1'b1;
    tick();
    dat_ready = 1'b0;
    checks++; if (evict_ready !== 1'b1) $display("FAIL full_ready_rise got=%b required=1", evict_ready); else passes++;
    checks++; if (occupancy !== 3'd3) $display("FAIL full_occ_free got=%0d required=3", occupancy); else passes++;
    model_alloc(48'h3_0000, pat(8'h55));
    tick();
    evict_valid = 1'b0; evict_dirty = 1'b0;
    checks++; if (occupancy !== 3'd4) $display("FAIL full_occ_refill got=%0d required=4", occupancy); else passes++;
    lookup_addr = 48'h3_0000;
    #1;
    checks++; if (lookup_data !== pat(8'h55)) $display("FAIL full_lookup got=%0h required=%0h", lookup_data[31:0], 32'h55555555); else passes++;
    drain_reqs();
    checks++; if (req_q.size() != 0) $display("FAIL full_entry2_req left=%0d required=0", req_q.size()); else passes++;
  endtask

  task automatic test_lookup();
    apply_reset();
    do_evict(48'h1000, pat(8'hD0), 1'b1);
    do_evict(48'h0040, pat(8'hD1), 1'b1);
    lookup_addr = 48'h007F;
    #1;
    checks++; if (lookup_hit !== 1'b1) $display("FAIL lookup_hit got=%b required=1", lookup_hit); else passes++;
    checks++; if (lookup_data !== pat(8'hD1)) $display("FAIL lookup_data got=%0h required=d1d1d1d1", lookup_data[31:0]); else passes++;
    lookup_addr = 48'h0080;
    #1;
    checks++; if (lookup_hit !== 1'b0 || lookup_data !== 512'h0) $display("FAIL lookup_miss got hit=%b data=%0h required hit=0 data=0", lookup_hit, lookup_data[31:0]); else passes++;
    lookup_addr = 48'h007F;
    drain_reqs();
    checks++; if (lookup_hit !== 1'b1) $display("FAIL lookup_inflight got=%b required=1", lookup_hit); else passes++;
    rsp_valid = 1'b1; rsp_txnid = 8'h01; rsp_dbid = 8'h11;
    dat_q.push_back('{1, 8'h11, pat(8'hD1)});
    tick();
    rsp_valid = 1'b0;
    // Free entry 1 and allocate a duplicate of line 0x1000 on the same edge.
    dat_ready = 1'b1;
    evict_valid = 1'b1; evict_addr = 48'h1000; evict_data = pat(8'hD2); evict_dirty = 1'b1;
    model_alloc(48'h1000, pat(8'hD2));
    tick();
    dat_ready = 1'b0; evict_valid = 1'b0; evict_dirty = 1'b0;
    checks++; if (occupancy !== 3'd2) $display("FAIL lookup_alloc_free_occ got=%0d required=2", occupancy); else passes++;
    checks++; if (lookup_hit !== 1'b0 || lookup_data !== 512'h0) $display("FAIL lookup_after_free got hit=%b data=%0h required hit=0 data=0", lookup_hit, lookup_data[31:0]); else passes++;
    lookup_addr = 48'h1000;
    #1;
    checks++; if (lookup_data !== pat(8'hD0)) $display("FAIL lookup_dup_lowest got=%0h required=d0d0d0d0", lookup_data[31:0]); else passes++;
  endtask

  task automatic test_unmatched_rsp();
    rsp_valid = 1'b1; rsp_txnid = 8'h03; rsp_dbid = 8'h99;
    tick();
    rsp_valid = 1'b0;
    checks++; if (rsp_err !== 1'b1) $display("FAIL unm_err got=%b required=1", rsp_err); else passes++;
    checks++; if (dat_valid !== 1'b0) $display("FAIL unm_dat_valid got=%b required=0", dat_valid); else passes++;
    checks++; if (occupancy !== 3'd2) $display("FAIL unm_occ got=%0d required=2", occupancy); else passes++;
    tick();
    checks++; if (rsp_err !== 1'b0) $display("FAIL unm_err_pulse got=%b required=0", rsp_err); else passes++;
    req_ready = 1'b1; rsp_valid = 1'b1; rsp_txnid = 8'h02; rsp_dbid = 8'h22;
    tick();
    req_ready = 1'b0; rsp_valid = 1'b0;
    checks++; if (rsp_err !== 1'b1) $display("FAIL same_cycle_err got=%b required=1", rsp_err); else passes++;
    checks++; if (dat_valid !== 1'b0) $display("FAIL same_cycle_dat got=%b required=0", dat_valid); else passes++;
    checks++; if (req_q.size() != 0) $display("FAIL same_cycle_req left=%0d required=0", req_q.size()); else passes++;
  endtask

  task automatic test_reset_mid();
    checks++; if (occupancy !== 3'd2) $display("FAIL mid_occ_before got=%0d required=2", occupancy); else passes++;
    rst_n = 1'b0;
    tick();
    checks++; if (occupancy !== 3'd0) $display("FAIL mid_occ got=%0d required=0", occupancy); else passes++;
    checks++; if (req_valid !== 1'b0 || dat_valid !== 1'b0) $display("FAIL mid_valids got req=%b dat=%b required 0 0", req_valid, dat_valid); else passes++;
    checks++; if (evict_ready !== 1'b1) $display("FAIL mid_ready got=%b required=1", evict_ready); else passes++;
    req_q.delete(); dat_q.delete(); busy = '0;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0; passes = 0; busy = '0;
    rst_n = 1'b0; evict_valid = 1'b0; evict_dirty = 1'b0; evict_addr = '0; evict_data = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_txnid = '0; rsp_dbid = '0;
    dat_ready = 1'b0; lookup_addr = '0;
    test_reset();
    test_single_dirty();
    test_clean();
    test_rr_order();
    test_full();
    test_lookup();
    test_unmatched_rsp();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/l1_wb_buffer.md
# l1_wb_buffer

Writeback buffer directly downstream of the L1 cache eviction interface in the RN-F node. It accepts victim lines and drops clean victims. Dirty victims are held in a small buffer and drained to the NoC as CHI-style WriteBackFull transactions: request out, CompDBIDResp in, data out. While a dirty line is in flight, the buffer serves lookups from the L1 fill path and snoop path, so a line being written back is never lost or refetched stale.

## Interface
- NUM_ENTRIES, 4, buffer depth (power of two, 2..16)
- TXNID_WIDTH, 8, transaction ID width; TxnID = entry index, zero-extended
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low; one clock; all state updates on posedge clk
- evict_valid / evict_ready  in/out  1/1  victim handshake from L1
- evict_addr  in  48  victim line address (bits [5:0] ignored, stored as 0)
- evict_data  in  512  victim data
- evict_dirty  in  1  1 = dirty, must be written back
- req_valid / req_ready  out/in  1/1  NoC request channel
- req_opcode  out  req_opcode_e  always REQ_WRITEBACK_FULL
- req_addr  out  48  line address
- req_txnid  out  TXNID_WIDTH  entry index
- rsp_valid  in  1  CompDBIDResp arrival (no ready; always accepted)
- rsp_txnid  in  TXNID_WIDTH  matches an entry's TxnID
- rsp_dbid  in  TXNID_WIDTH  ID to use on data
- dat_valid / dat_ready  out/in  1/1  NoC write-data channel
- dat_txnid  out  TXNID_WIDTH  captured DBID
- dat_data  out  512  line data
- lookup_addr  in  48  line address from fill/snoop path
- lookup_hit  out  1  a non-FREE entry holds lookup_addr's line
- lookup_data  out  512  that entry's data (0 on miss)
- rsp_err  out  1  one-cycle pulse on an unmatched rsp
- occupancy  out  $clog2(NUM_ENTRIES)+1  count of non-FREE entries

## Operation
- Per-entry FSM with states FREE, REQ, WAIT_DBID and DATA.
  - FREE→REQ on allocation.
  - REQ→WAIT_DBID on the req handshake for that entry.
  - WAIT_DBID→DATA on rsp_valid with rsp_txnid == index; rsp_dbid is stored.
  - DATA→FREE on the dat handshake.
- Allocation: lowest-index FREE entry; captures addr (offset zeroed) and data.
- Clean victim (evict_dirty=0): accepted whenever evict_ready=1. No entry is allocated and no traffic is generated.
- evict_ready = (any entry FREE). This is computed from current state only, so a same-cycle free does not raise ready.
- Request arbitration: round-robin among REQ entries. The pointer advances past the granted entry after each handshake.
- Data arbitration: round-robin among DATA entries, using a separate pointer.
- Once req_valid or dat_valid is asserted, the presented entry is held stable until the handshake completes.
- rsp_valid whose txnid does not name a WAIT_DBID entry: ignored, and rsp_err pulses the next cycle.
- Lookup is combinational over non-FREE entries. If several entries match, the lowest index wins. Lookup never changes state.
- Duplicate addresses are legal. Each entry drains independently.

## Timing
- Reset values:
  - all entries FREE; evict_ready=1
  - req_valid=0, dat_valid=0
  - req_opcode=REQ_WRITEBACK_FULL, req_addr=0, req_txnid=0
  - dat_txnid=0, dat_data=0, lookup_data=0
  - lookup_hit=0, rsp_err=0, occupancy=0
- Entry allocated at edge N shows req_valid from cycle N+1 (registered state). Minimum request latency is 1 cycle.
- rsp at edge M shows dat_valid from cycle M+1.
- Dat handshake at edge K frees the entry at K; evict_ready rises in cycle K+1.
- Simultaneous alloc and free in one cycle: both take effect, and occupancy is unchanged.
- Simultaneous req handshake and rsp on different entries: both take effect.
- An rsp for an entry in the same cycle as its req handshake is unmatched (the entry is still in REQ).
- rst_n low mid-transaction: all entries become FREE on the next edge. In-flight transactions are abandoned; the NoC side is reset together.
- Occupancy saturates at NUM_ENTRIES; evict_ready=0 while full.

## Structure
- coh_noc_pkg additions:
  - wb_state_e (FREE, REQ, WAIT_DBID, DATA)
  - REQ_WRITEBACK_FULL in req_opcode_e, if not already present
  - LINE_OFFSET_W=6 constant
- Sub-module: rr_arbiter (N requests, one-hot grant, advance input), instantiated twice (req and dat).
- Entry storage: flat arrays in this module.

## Test plan
- Single dirty evict, addr 0x1234_5678_9A40, data pattern A5.
  - req_valid at +1 cycle with txnid 0.
  - rsp dbid 0x3C gives dat_valid next cycle with dat_txnid 0x3C and data A5.
  - Entry frees; occupancy returns to 0.
- Clean evict: accepted in one cycle; req_valid stays 0; occupancy stays 0.
- Fill to 4 entries with req_ready=0.
  - evict_ready=0; a 5th evict is stalled.
  - Complete entry 2's data handshake; evict_ready=1 the next cycle; the new victim lands in entry 2.
- Three entries in REQ with req_ready=1: grants come in order 0,1,2. rsps arrive reversed (2,1,0) and dat order follows rsp order.
- While entry 1 holds line 0x40, lookup_addr 0x7F gives hit=1 with entry-1 data. After its dat handshake, the same lookup gives hit=0 and data 0.
- rsp_txnid 3 while entry 3 is FREE: rsp_err pulses one cycle and no state changes. Assert rst_n=0 with 2 entries in WAIT_DBID: next edge occupancy=0 and all valids low.
